// File: rtl/serialiser.sv
// serialiser -- ISO/IEC 14443-3A PICC transmit-path byte-to-bit converter.
//
// Takes bytes from the frame builder over a valid/ready handshake and emits
// them LSbit first, one bit per out_req consume strobe, to the frame
// encoder. When built with SERIALISER_PARITY_EN defined, the ISO 14443A
// parity bit follows every full byte. The default build (macro undefined)
// has no parity state or register, so a full byte is 8 bits. Partial final
// bytes (in_bits 1..7 with in_last=1) never carry parity. A missing
// follow-on byte aborts the frame with a one-cycle underrun pulse.
//
// Parameters:
//   PARITY_ODD  1 = odd parity (ISO 14443A), 0 = even parity (test only).
//               Only meaningful when SERIALISER_PARITY_EN is defined.
//
// Ports:
//   clk        in   13.56 MHz clock
//   rst        in   asynchronous active-high reset
//   in_data    in   [7:0] byte to send, bit 0 first
//   in_bits    in   [2:0] valid bits of a final byte (0 means 8)
//   in_last    in   byte is the last of the frame
//   in_valid   in   in_data/in_bits/in_last are valid
//   in_ready   out  byte accepted on an edge with in_valid && in_ready
//   out_data   out  current bit
//   out_valid  out  out_data/out_last are valid
//   out_last   out  current bit is the final bit of the frame
//   out_req    in   single-cycle consume strobe from the encoder
//   underrun   out  one-cycle pulse: frame aborted, next byte missing
//   busy       out  a frame is in progress
module serialiser #(
  parameter int PARITY_ODD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [2:0] in_bits,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_req,
  output logic       underrun,
  output logic       busy
);

  // Elaboration-time sanity check on the parity selector.
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_param_check
    $error("serialiser: PARITY_ODD must be 0 or 1");
  end

`ifdef SERIALISER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
  } state_t;
`endif

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [3:0] len_reg, len_next;
  logic       last_reg, last_next;
  logic       underrun_reg, underrun_next;
`ifdef SERIALISER_PARITY_EN
  logic       parity_reg, parity_next;
`endif

  logic ready;
  logic load;
  logic byte_done;
  logic final_data;
  logic full_byte;
  logic data_bit;
  logic last_bit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= 8'h00;
      cnt_reg      <= 3'd0;
      len_reg      <= 4'd8;
      last_reg     <= 1'b0;
      underrun_reg <= 1'b0;
`ifdef SERIALISER_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      last_reg     <= last_next;
      underrun_reg <= underrun_next;
`ifdef SERIALISER_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    len_next      = len_reg;
    last_next     = last_reg;
    underrun_next = 1'b0;
`ifdef SERIALISER_PARITY_EN
    parity_next   = parity_reg;
`endif
    ready      = 1'b0;
    load       = 1'b0;
    byte_done  = 1'b0;
    data_bit   = 1'b0;
    last_bit   = 1'b0;
    final_data = ({1'b0, cnt_reg} == (len_reg - 4'd1));
`ifdef SERIALISER_PARITY_EN
    // Only full bytes are followed by a parity bit.
    full_byte  = (len_reg == 4'd8);
`else
    full_byte  = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
        end
      end

      DATA: begin
        data_bit = shift_reg[0];
        // Last data bit is the frame's final bit unless parity follows it.
        if (final_data && !full_byte) begin
          last_bit = last_reg;
        end
        if (out_req) begin
          if (!final_data) begin
            shift_next = {1'b0, shift_reg[7:1]};
            cnt_next   = cnt_reg + 3'd1;
          end else if (full_byte) begin
`ifdef SERIALISER_PARITY_EN
            state_next = PARITY;
`endif
          end else begin
            byte_done = 1'b1;
          end
        end
      end

`ifdef SERIALISER_PARITY_EN
      PARITY: begin
        data_bit = parity_reg;
        last_bit = last_reg;
        if (out_req) begin
          byte_done = 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // End of byte: finish the frame, chain the next byte with no bubble,
    // or abort with underrun if the frame builder has nothing ready.
    if (byte_done) begin
      if (last_reg) begin
        state_next = IDLE;
      end else begin
        ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
        end else begin
          underrun_next = 1'b1;
          state_next    = IDLE;
        end
      end
    end

    if (load) begin
      state_next = DATA;
      shift_next = in_data;
      cnt_next   = 3'd0;
      len_next   = (in_last && (in_bits != 3'd0)) ? {1'b0, in_bits} : 4'd8;
      last_next  = in_last;
`ifdef SERIALISER_PARITY_EN
      parity_next = (PARITY_ODD != 0) ? ~^in_data : ^in_data;
`endif
    end
  end

  // in_ready is forced low while reset is held.
  assign in_ready  = ready && !rst;
  assign out_data  = data_bit;
  assign out_valid = (state_reg != IDLE);
  assign out_last  = last_bit;
  assign underrun  = underrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serialiser.sv
// tb_serialiser -- directed self-checking bench for serialiser.
// Works for both builds; expected bit counts and patterns depend on whether
// SERIALISER_PARITY_EN is defined.
module tb_serialiser;

`ifdef SERIALISER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_bits;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_req;
  logic       underrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Upstream byte table for the current frame
  logic [7:0] tx_data [4];
  logic [2:0] tx_bits [4];
  logic       tx_last [4];

  // Observations collected by run_frame
  logic [63:0] rx_vec;
  int rx_cnt, last_cnt, last_pos, ov_cnt, ov_first, ov_last;
  int und_cnt, und_cyc, acc0, last_cons, unstable;
  logic und_ov, und_busy, rdy_after;

  serialiser #(.PARITY_ODD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_bits   (in_bits),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_req   (out_req),
    .underrun  (underrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Feed n bytes from the table (in_valid high while bytes remain) and
  // consume bits with out_req high every period-th cycle, for max_cyc cycles.
  task automatic run_frame(input int n, input int period, input int max_cyc);
    int idx;
    int after_last;
    logic acc, cons, od, ol, prev_hold, prev_d;
    idx = 0; after_last = -1; prev_hold = 1'b0; prev_d = 1'b0;
    rx_vec = '0; rx_cnt = 0; last_cnt = 0; last_pos = -1;
    ov_cnt = 0; ov_first = -1; ov_last = -1;
    und_cnt = 0; und_cyc = -1; und_ov = 1'b1; und_busy = 1'b1;
    acc0 = -1; last_cons = -1; unstable = 0; rdy_after = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      in_valid = (idx < n);
      if (idx < n) begin
        in_data = tx_data[idx];
        in_bits = tx_bits[idx];
        in_last = tx_last[idx];
      end
      out_req = ((c % period) == (period - 1));
      #1;
      if (c == after_last) rdy_after = in_ready;
      if (underrun) begin
        und_cnt++; und_cyc = c; und_ov = out_valid; und_busy = busy;
      end
      if (out_valid) begin
        ov_cnt++;
        if (ov_first < 0) ov_first = c;
        ov_last = c;
        if (prev_hold && (out_data !== prev_d)) unstable++;
      end
      prev_hold = out_valid && !out_req;
      prev_d = out_data;
      acc = in_valid && in_ready;
      cons = out_valid && out_req;
      od = out_data;
      ol = out_last;
      @(posedge clk);
      if (acc) begin
        if (idx == 0) acc0 = c;
        idx++;
      end
      if (cons) begin
        if (rx_cnt < 64) rx_vec[rx_cnt] = od;
        rx_cnt++;
        last_cons = c;
        if (ol) begin
          last_cnt++; last_pos = rx_cnt - 1; after_last = c + 1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_req = 1'b0;
    $display("frame: bytes=%0d bits=%0d pattern=0x%0h lasts=%0d underruns=%0d", n, rx_cnt, rx_vec, last_cnt, und_cnt);
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_bits = 3'd0; in_last = 1'b0;
    in_valid = 1'b0; out_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // REQA short frame: 0x26, 7 bits, no parity
    tx_data[0] = 8'h26; tx_bits[0] = 3'd7; tx_last[0] = 1'b1;
    run_frame(1, 1, 12);
    check("reqa_bits", rx_cnt, 7);
    check("reqa_pattern", rx_vec, 64'h26);
    check("reqa_last_cnt", last_cnt, 1);
    check("reqa_last_pos", last_pos, 6);
    check("reqa_latency", ov_first, acc0 + 1);
    check("reqa_ready_after", rdy_after, 1);
    check("reqa_underrun", und_cnt, 0);

    // Two-byte frame 0x93, 0x20 (last, in_bits=0 means 8), out_req held high
    tx_data[0] = 8'h93; tx_bits[0] = 3'd5; tx_last[0] = 1'b0;
    tx_data[1] = 8'h20; tx_bits[1] = 3'd0; tx_last[1] = 1'b1;
    run_frame(2, 1, 24);
    check("two_bits", rx_cnt, 16 + 2 * PB);
    check("two_pattern", rx_vec, (PB != 0) ? 64'h4193 : 64'h2093);
    check("two_last_cnt", last_cnt, 1);
    check("two_last_pos", last_pos, 15 + 2 * PB);
    check("two_ov_cnt", ov_cnt, 16 + 2 * PB);
    check("two_ov_contig", ov_last - ov_first + 1, 16 + 2 * PB);
    check("two_ready_after", rdy_after, 1);
    check("two_busy_end", busy, 0);

    // Underrun: 0x93 not last, nothing follows
    tx_data[0] = 8'h93; tx_bits[0] = 3'd0; tx_last[0] = 1'b0;
    run_frame(1, 1, 14);
    check("und_bits", rx_cnt, 8 + PB);
    check("und_pulses", und_cnt, 1);
    check("und_cycle", und_cyc, last_cons + 1);
    check("und_out_valid", und_ov, 0);
    check("und_busy", und_busy, 0);
    check("und_no_last", last_cnt, 0);

    // Sparse out_req every 16 cycles, 0xFF last
    tx_data[0] = 8'hFF; tx_bits[0] = 3'd0; tx_last[0] = 1'b1;
    run_frame(1, 16, 160);
    check("sparse_bits", rx_cnt, 8 + PB);
    check("sparse_pattern", rx_vec, (PB != 0) ? 64'h1FF : 64'hFF);
    check("sparse_stable", unstable, 0);
    check("sparse_last_pos", last_pos, 7 + PB);

    // Reset after the 4th bit of 0x55
    tx_data[0] = 8'h55; tx_bits[0] = 3'd0; tx_last[0] = 1'b0;
    run_frame(1, 1, 5);
    #1;
    check("mid_bits", rx_cnt, 4);
    check("mid_busy", busy, 1);
    check("mid_bit4", out_data, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_underrun", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    tx_data[0] = 8'h01; tx_bits[0] = 3'd0; tx_last[0] = 1'b1;
    run_frame(1, 1, 14);
    check("fresh_bits", rx_cnt, 8 + PB);
    check("fresh_pattern", rx_vec, 64'h01);
    check("fresh_last_pos", last_pos, 7 + PB);
    check("fresh_underrun", und_cnt, 0);

    // Single full last byte 0x93
    tx_data[0] = 8'h93; tx_bits[0] = 3'd0; tx_last[0] = 1'b1;
    run_frame(1, 1, 14);
    check("full_bits", rx_cnt, 8 + PB);
    check("full_pattern", rx_vec, (PB != 0) ? 64'h193 : 64'h93);
    check("full_last_pos", last_pos, 7 + PB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serialiser.md
# serialiser

Transmit-path byte-to-bit converter for the ISO/IEC 14443-3A PICC stack. It accepts bytes from the frame-building logic over a valid/ready handshake and presents them LSbit first, one bit at a time, to the downstream frame encoder. It inserts the ISO 14443A parity bit after every full byte, supports a partial final byte for bit-oriented anticollision frames, and flags underrun if a frame's next byte is missing.

## Interface
Parameters:
- PARITY_ODD, default 1: 1 gives odd parity, as ISO 14443A requires; 0 gives even parity, for test only.

Ports:
- clk  in  1  13.56 MHz clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  byte to send; bit 0 is sent first.
- in_bits  in  3  number of valid bits in a final byte. 0 means 8. Honoured only when in_last=1; otherwise treated as 8.
- in_last  in  1  the byte is the last of the frame.
- in_valid  in  1  in_data/in_bits/in_last are valid.
- in_ready  out  1  the byte is accepted on a clock edge where in_valid && in_ready.
- out_data  out  1  current bit.
- out_valid  out  1  out_data/out_last are valid.
- out_last  out  1  the current bit is the final bit of the frame.
- out_req  in  1  single-cycle consume strobe from the encoder; ignored while out_valid=0.
- underrun  out  1  one-cycle pulse: the frame was aborted because the next byte was not available.
- busy  out  1  a frame is in progress (state is not IDLE).

## Operation
- State machine has three states: IDLE, DATA and PARITY.
- Registers:
  - 8-bit shift register.
  - 3-bit bit counter.
  - Byte length: 4 bits, values 1..8.
  - Latched last flag.
  - Running parity bit.
- IDLE:
  - in_ready=1.
  - On accept: load all registers, clear the counter, go to DATA.
- DATA: out_data = shift[0]. On out_req:
  - If the counter is below length-1: shift right and increment the counter.
  - Else, if the byte is full (length 8) and parity is compiled in: go to PARITY.
  - Else: go to end-of-byte handling.
- PARITY:
  - out_data = parity. For PARITY_ODD=1 this is ~^byte; for PARITY_ODD=0 it is ^byte.
  - On out_req: go to end-of-byte handling.
- End-of-byte handling:
  - If the latched last flag is set: go to IDLE.
  - Else, if in_valid=1: accept the next byte in the same cycle and load it directly, so there is no bubble.
  - Else: pulse underrun, go to IDLE, and drop out_valid. The frame is aborted and no out_last is produced.
- in_ready is combinational. It is 1 in IDLE, or when out_req consumes the final bit of a non-last byte. It is 0 at all other times.
- out_last = latched last flag && the current bit is the frame's final bit. The final bit is the parity bit for a full byte, or the last data bit for a partial byte or when parity is compiled out.
- Partial bytes (in_bits 1..7 with in_last=1) never carry parity.

## Timing
- Reset values:
  - in_ready=0 while rst=1, then 1 from the first cycle after release.
  - out_data=0, out_valid=0, out_last=0, underrun=0, busy=0.
  - State is IDLE.
- Reset mid-frame clears everything immediately. No out_last or underrun is generated.
- Latency: the byte is accepted at edge N; out_valid=1 with bit 0 is visible after edge N (cycle N+1).
- Each out_req at an edge advances the bit on the next cycle. With out_req held high, throughput is 1 bit/clk, including across byte boundaries.
- A full byte takes 9 consumes with parity compiled in, and 8 without.
- After the consume of the out_last bit, out_valid=0 and busy=0 in the next cycle. in_ready is 1 in that same cycle, so a new frame can be accepted immediately.
- in_valid while in_ready=0 has no effect, and the upstream holds its data.
- underrun is asserted for exactly 1 cycle, the cycle after the failing consume.

## Configuration
- SERIALISER_PARITY_EN defined:
  - PARITY state and parity register are present.
  - A full byte is 9 bits.
- SERIALISER_PARITY_EN undefined:
  - No PARITY state or parity register.
  - A full byte is 8 bits, and out_last falls on the last data bit.
  - PARITY_ODD is unused.

## Test plan
- REQA short frame: 0x26 with in_bits=7, in_last=1 -> bits 0,1,1,0,0,1,0. No parity. out_last on the 7th bit.
- Two-byte frame: 0x93 then 0x20 (in_last), out_req held high:
  - Bits for 0x93: 1,1,0,0,1,0,0,1, parity 1.
  - Bits for 0x20: 0,0,0,0,0,1,0,0, parity 0.
  - out_valid continuous for 18 cycles. out_last on the 18th bit only.
- Underrun: 0x93 without in_last, and in_valid=0 at the consume of its parity bit -> one-cycle underrun, out_valid=0, busy=0, no out_last.
- Sparse out_req every 16 cycles with byte 0xFF -> out_data stays 1 for 8 bits, then parity 1 (odd). Each bit is held stable until consumed.
- Reset asserted after the 4th bit of 0x55 -> all outputs 0 on the next cycle. A fresh 0x01 frame after release serialises as 1,0,0,0,0,0,0,0, parity 0.
- Build without SERIALISER_PARITY_EN: 0x93 with in_last -> 8 bits, out_last on bit 8.
